// File: rtl/debug_console.sv
// Character console: register writes feed a FIFO drained on a valid/ready byte port; HALT drains then stops.
// Optional macro DEBUG_CONSOLE_SIM_PRINT_EN adds simulation-only echo of characters and $finish on halt.
module debug_console #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [1:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              halted,
  output logic [CNT_W-1:0]  char_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              enable;
  logic [1:0]        state;

  logic        empty;
  logic        full;
  logic        pop;
  logic        push_req;
  logic        do_push;
  logic        ctrl_wr;
  logic        clear;
  logic [31:0] status;
  logic [31:0] rd_value;
  logic [31:0] unused_wr;

  assign unused_wr = wr_data;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign out_valid = !empty && (enable || state == ST_DRAIN);
  assign out_data  = mem[rd_ptr];
  assign halted    = (state == ST_HALTED);
  assign pop       = out_valid && out_ready;
  assign push_req  = wr_en && wr_addr == 2'd0 && state == ST_RUN;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push_req && (!full || pop);
  assign ctrl_wr   = wr_en && wr_addr == 2'd1;
  assign clear     = ctrl_wr && wr_data[1];

  assign status = {16'(char_count), 8'(level), 3'b000, enable, halted, overflow, full, empty};

  always_comb begin
    rd_value = '0;
    case (rd_addr)
      2'd1:    rd_value = {31'b0, enable};
      2'd3:    rd_value = status;
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      enable     <= 1'b1;
      state      <= ST_RUN;
      rd_data    <= '0;
      char_count <= '0;
    end else begin
      // Clear overrides any concurrent pop, but the handshake is still counted below.
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        level    <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !pop)      level <= level + 1'b1;
        else if (!do_push && pop) level <= level - 1'b1;
        if (push_req && full && !pop) overflow <= 1'b1;
      end

      if (ctrl_wr) enable <= wr_data[0];
      if (pop)     char_count <= char_count + CNT_W'(1);
      if (rd_en)   rd_data <= rd_value;

      case (state)
        ST_RUN:    if (wr_en && wr_addr == 2'd2) state <= ST_DRAIN;
        ST_DRAIN:  if (empty) state <= ST_HALTED;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

`ifdef DEBUG_CONSOLE_SIM_PRINT_EN
  always @(posedge clk) begin
    if (!rst && pop) $write("%c", out_data);
    if (!rst && state == ST_DRAIN && empty) begin
      $display("console halted, %0d chars", char_count);
      $finish;
    end
  end
`else
  // Synthesizable build: no simulation side effects.
`endif

endmodule

// File: tb/tb_debug_console.sv
// Self-checking bench for debug_console: directed scenarios plus a random mix against a queue-based model.
module tb_debug_console;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        halted;
  logic [15:0] char_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the FIFO is a queue, the control state is a pair of flags.
  logic [7:0]  q[$];
  bit          m_ovf;
  bit          m_en;
  bit          m_drain;
  bit          m_halt;
  logic [15:0] m_count;
  logic [31:0] m_rd;

  debug_console dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .halted(halted), .char_count(char_count)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    return q.size() != 0 && (m_en || m_drain);
  endfunction

  function automatic logic [31:0] m_status();
    logic [7:0] lvl;
    lvl = 8'(q.size());
    return {m_count, lvl, 3'b000, m_en, m_halt, m_ovf, q.size() == DEPTH, q.size() == 0};
  endfunction

  task automatic model_next();
    bit was_empty, was_full, was_drain, running, pop;
    logic [7:0] tmp;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_en = 1; m_drain = 0; m_halt = 0;
      m_count = '0; m_rd = '0;
      return;
    end
    was_empty = q.size() == 0;
    was_full  = q.size() == DEPTH;
    was_drain = m_drain;
    running   = !m_drain && !m_halt;
    pop       = m_valid() && out_ready;
    if (rd_en) begin
      case (rd_addr)
        2'd1:    m_rd = {31'b0, m_en};
        2'd3:    m_rd = m_status();
        default: m_rd = '0;
      endcase
    end
    if (pop) begin
      tmp = q.pop_front();
      m_count = m_count + 16'd1;
    end
    if (was_drain && was_empty) begin
      m_drain = 0;
      m_halt  = 1;
    end
    if (wr_en) begin
      case (wr_addr)
        2'd0: if (running) begin
          if (was_full && !pop) m_ovf = 1;
          else q.push_back(wr_data[7:0]);
        end
        2'd1: begin
          m_en = wr_data[0];
          if (wr_data[1]) begin
            q.delete();
            m_ovf = 0;
          end
        end
        2'd2: if (running) m_drain = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
  endtask

  task automatic do_read(input logic [1:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
    n_vec++; if (char_count !== 16'd0) begin n_err++; $display("[TB] FAIL reset_count got %0d want 0", char_count); end
    do_read(2'd3);
    n_vec++; if (rd_data !== 32'h0000_0011) begin n_err++; $display("[TB] FAIL reset_status got %h want 00000011", rd_data); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h48; exp_seq[1] = 8'h69; exp_seq[2] = 8'h21;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_write(2'd0, ($urandom & 32'hFFFF_FF00) | 32'(exp_seq[k]));
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
        n_err++; $display("[TB] FAIL stream_char%0d got v=%b %h want v=1 %h", k, out_valid, out_data, exp_seq[k]);
      end
    end
    step();
    n_vec++; if (char_count !== 16'd3 || char_count !== m_count) begin n_err++; $display("[TB] FAIL stream_count got %0d want 3", char_count); end
    do_read(2'd3);
    n_vec++; if (rd_data !== m_rd || rd_data[0] !== 1'b1) begin n_err++; $display("[TB] FAIL stream_status got %h want %h", rd_data, m_rd); end
  endtask

  task automatic test_overflow();
    int got;
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) do_write(2'd0, 32'h41 + 32'(i));
    do_read(2'd3);
    n_vec++;
    if (rd_data !== m_rd || rd_data[15:8] !== 8'd16 || rd_data[1] !== 1'b1 || rd_data[2] !== 1'b1) begin
      n_err++; $display("[TB] FAIL ovf_status got %h want %h", rd_data, m_rd);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      n_vec++; if (out_valid !== m_valid()) begin n_err++; $display("[TB] FAIL ovf_valid got %b want %b", out_valid, m_valid()); end
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out_data !== 8'(8'h41 + got)) begin
          n_err++; $display("[TB] FAIL ovf_char%0d got %h want %h", got, out_data, 8'(8'h41 + got));
        end
        got++;
      end
      step();
    end
    n_vec++; if (got != 16) begin n_err++; $display("[TB] FAIL ovf_drained got %0d want 16", got); end
    do_write(2'd1, 32'h3);
    do_read(2'd3);
    n_vec++; if (rd_data !== m_rd || rd_data[2] !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_clear got %h want %h", rd_data, m_rd); end
  endtask

  task automatic test_disable();
    logic [7:0] ch [2];
    int got;
    ch[0] = 8'($urandom); ch[1] = 8'($urandom);
    do_write(2'd1, 32'h0);
    out_ready = 1'b1;
    do_write(2'd0, 32'(ch[0]));
    do_write(2'd0, 32'(ch[1]));
    for (int c = 0; c < 10; c++) begin
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL dis_gated cyc%0d got %b want 0", c, out_valid); end
      step();
    end
    do_write(2'd1, 32'h1);
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out_data !== ch[got]) begin n_err++; $display("[TB] FAIL dis_char%0d got %h want %h", got, out_data, ch[got]); end
        got++;
      end
      step();
    end
    n_vec++; if (got != 2 || char_count !== m_count) begin n_err++; $display("[TB] FAIL dis_emitted got %0d want 2", got); end
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom);
      sel = int'($urandom % 8);
      wr_addr = (sel < 5) ? 2'd0 : (sel == 5) ? 2'd1 : 2'd3;
      if (wr_addr == 2'd1) wr_data = {30'($urandom), ($urandom % 16) == 0, ($urandom % 5) != 0};
      else wr_data = $urandom;
      rd_en = 1'($urandom);
      rd_addr = 2'($urandom);
      out_ready = 1'($urandom);
      step();
      n_vec++; if (out_valid !== m_valid()) begin n_err++; $display("[TB] FAIL rnd_valid i=%0d got %b want %b", i, out_valid, m_valid()); end
      if (m_valid()) begin
        n_vec++; if (out_data !== q[0]) begin n_err++; $display("[TB] FAIL rnd_data i=%0d got %h want %h", i, out_data, q[0]); end
      end
      n_vec++; if (char_count !== m_count) begin n_err++; $display("[TB] FAIL rnd_count i=%0d got %0d want %0d", i, char_count, m_count); end
      n_vec++; if (rd_data !== m_rd) begin n_err++; $display("[TB] FAIL rnd_rd i=%0d got %h want %h", i, rd_data, m_rd); end
      n_vec++; if (halted !== m_halt) begin n_err++; $display("[TB] FAIL rnd_halted i=%0d got %b want %b", i, halted, m_halt); end
    end
  endtask

  task automatic test_halt_drain();
    logic [15:0] prev;
    bit found;
    do_reset(1);
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (c < 4) begin wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'h30 + 32'(c); end
      else if (c == 4) begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = $urandom; end
      out_ready = (c % 2) == 0;
      prev = m_count;
      step();
      if (prev == 16'd3 && m_count == 16'd4) begin
        found = 1;
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("[TB] FAIL halt_early got %b want 0", halted); end
        out_ready = 1'b0;
        step();
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("[TB] FAIL halt_rise got %b want 1", halted); end
      end
    end
    n_vec++; if (!found) begin n_err++; $display("[TB] FAIL halt_timeout got %0d handshakes want 4", m_count); end
    out_ready = 1'b1;
    do_write(2'd0, 32'h55);
    do_write(2'd0, 32'h66);
    do_read(2'd3);
    n_vec++;
    if (rd_data !== m_rd || rd_data[15:8] !== 8'd0 || rd_data[2] !== 1'b0 || rd_data[3] !== 1'b1) begin
      n_err++; $display("[TB] FAIL halt_status got %h want %h", rd_data, m_rd);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL halt_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] ch;
    do_reset(1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write(2'd0, 32'h61 + 32'(i));
    do_write(2'd2, 32'h0);
    step();
    do_reset(1);
    n_vec++; if (out_valid !== 1'b0 || halted !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst got v=%b h=%b want 0 0", out_valid, halted); end
    do_read(2'd3);
    n_vec++; if (rd_data !== 32'h0000_0011) begin n_err++; $display("[TB] FAIL mid_rst_status got %h want 00000011", rd_data); end
    ch = 8'($urandom);
    out_ready = 1'b1;
    do_write(2'd0, 32'(ch));
    n_vec++; if (out_valid !== 1'b1 || out_data !== ch) begin n_err++; $display("[TB] FAIL mid_rst_push got v=%b %h want v=1 %h", out_valid, out_data, ch); end
    step();
    n_vec++; if (char_count !== 16'd1) begin n_err++; $display("[TB] FAIL mid_rst_count got %0d want 1", char_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_disable();
    test_random();
    test_halt_drain();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
